// File: rtl/ai_accel_pkg.sv
// rtl/ai_accel_pkg.sv - shared types and defaults for the compute-core driver
package ai_accel_pkg;

  localparam int DRV_DATA_WIDTH     = 32;
  localparam int DRV_TIMEOUT_CYCLES = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } drv_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with a registered full flag and occupancy count
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_next;
  logic                  do_push;
  logic                  do_pop;

  // Requests at full/empty are dropped here so callers can pass raw valids.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/ai_core_driver.sv
// rtl/ai_core_driver.sv - issues buffered operands to one compute core and returns its results
module ai_core_driver
  import ai_accel_pkg::*;
#(
  parameter int DATA_WIDTH     = DRV_DATA_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = DRV_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_WIDTH-1:0]         core_data,
  output logic                          core_valid,
  input  logic [DATA_WIDTH-1:0]         core_result,
  input  logic                          core_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          busy,
  output logic                          err_timeout,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  drv_state_t            state;
  logic [TW-1:0]         tmo_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  start;
  logic                  capture;
  logic                  expire;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (start),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign s_ready = !fifo_full;

  // The output slot counts as free when the held result leaves this same cycle.
  assign start   = (state == ST_IDLE) && !fifo_empty && (!m_valid || m_ready);
  assign capture = (state == ST_WAIT) && core_ready;
  assign expire  = (state == ST_WAIT) && !core_ready && (tmo_cnt == TMO_LAST);
  assign busy    = (state != ST_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      core_valid <= 1'b0;
      core_data  <= '0;
    end else begin
      core_valid <= start;
      case (state)
        ST_IDLE: begin
          if (start) begin
            core_data <= fifo_head;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (capture) begin
            state <= ST_IDLE;
          end else if (expire) begin
            state <= ST_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        // Guard cycle: a late core_ready lands here and is discarded.
        ST_HOLD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (capture) begin
      m_valid <= 1'b1;
      m_data  <= core_result;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_timeout <= 1'b0;
    end else if (expire) begin
      err_timeout <= 1'b1;
    end else if (err_clr) begin
      err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ai_core_driver.sv
// tb/tb_ai_core_driver.sv - directed and randomized bench for ai_core_driver with a core model
module tb_ai_core_driver;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] core_data;
  logic          core_valid;
  logic [DW-1:0] core_result = '0;
  logic          core_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          err_timeout;
  logic          err_clr = 1'b0;
  logic [2:0]    fifo_count;

  ai_core_driver #(
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .core_data   (core_data),
    .core_valid  (core_valid),
    .core_result (core_result),
    .core_ready  (core_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int            checks = 0;
  int            errors = 0;
  int            acc_total = 0;
  int            iss_total = 0;
  int            pulses = 0;
  int            out_total = 0;
  int            since_cv = 100;
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] exp_q[$];
  logic          prev_mv = 1'b0;
  logic          prev_mr = 1'b0;
  logic [DW-1:0] prev_md = '0;
  bit            saw_not_ready = 1'b0;
  int            core_delay = 2;
  int            rem = 0;
  logic [DW-1:0] pend = '0;
  bit            inj_req = 1'b0;
  int            t0, p0, o0, n, sent;
  bit            go;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference view: words leave the FIFO in order, each answered by data+1 unless the core is mute.
  task automatic monitor();
    if (!reset_n) begin
      in_q.delete();
      exp_q.delete();
      acc_total = 0;
      iss_total = 0;
      prev_mv   = 1'b0;
      since_cv  = 100;
      return;
    end
    since_cv++;
    if (core_valid) begin
      check("issue_gap_ge3", since_cv >= 3, 1);
      since_cv = 0;
      iss_total++;
      pulses++;
      if (in_q.size() == 0) check("issue_without_word", 1, 0);
      else check("core_data_order", core_data, in_q.pop_front());
    end
    check("fifo_count", fifo_count, acc_total - iss_total);
    check("s_ready", s_ready, (acc_total - iss_total) < DEPTH);
    if (!s_ready) saw_not_ready = 1'b1;
    if (s_valid && s_ready) begin
      acc_total++;
      in_q.push_back(s_data);
      if (core_delay != 0) exp_q.push_back(s_data + 32'd1);
    end
    if (prev_mv && !prev_mr) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, prev_md);
    end
    if (m_valid && m_ready) begin
      out_total++;
      if (exp_q.size() == 0) check("unexpected_result", 1, 0);
      else check("m_data_order", m_data, exp_q.pop_front());
    end
    prev_mv = m_valid;
    prev_mr = m_ready;
    prev_md = m_data;
  endtask

  task automatic core_step();
    core_ready  = 1'b0;
    core_result = $urandom;
    if (!reset_n) begin
      rem = 0;
      return;
    end
    if (inj_req) begin
      core_ready = 1'b1;
      inj_req    = 1'b0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        core_ready  = 1'b1;
        core_result = pend + 32'd1;
      end
    end
    if (core_valid) begin
      pend = core_data;
      rem  = (core_delay == 255) ? int'($urandom_range(1, 4)) : core_delay;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    core_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    int k = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && k < 200) begin
      tick();
      k++;
    end
    check("push_accept", s_ready, 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((busy || m_valid || exp_q.size() != 0) && k < 300) begin
      tick();
      k++;
    end
    check("drain_idle", {busy, m_valid}, 2'b00);
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish by 500000 ns, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    check("rst_s_ready", s_ready, 1);
    check("rst_core_valid", core_valid, 0);
    check("rst_core_data", core_data, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_count", fifo_count, 0);
    reset_n = 1'b1;
    m_ready = 1'b1;
    repeat (2) tick();

    // Single word: latency counted from the cycle s_valid is first presented.
    p0 = pulses;
    t0 = cyc;
    s_data  = 32'h10;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 50) begin tick(); n++; end
    check("single_latency", cyc - t0, 5);
    check("single_m_data", m_data, 32'h11);
    drain();
    check("single_pulses", pulses - p0, 1);
    check("single_busy", busy, 0);

    // Back-to-back with an always-ready sink.
    p0 = pulses;
    o0 = out_total;
    saw_not_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(DW'(i));
    drain();
    check("b2b_pulses", pulses - p0, 5);
    check("b2b_outputs", out_total - o0, 5);
    check("b2b_s_ready_dropped", saw_not_ready, 1);

    // Backpressure: the second word must wait for the first result to leave.
    m_ready = 1'b0;
    o0 = out_total;
    push_word(32'hA0);
    push_word(32'hB0);
    n = 0;
    while (!m_valid && n < 50) begin tick(); n++; end
    check("bp_first", m_data, 32'hA1);
    p0 = pulses;
    repeat (20) tick();
    check("bp_no_issue", pulses - p0, 0);
    check("bp_valid_held", {m_valid, m_data}, {1'b1, 32'hA1});
    check("bp_queued", fifo_count, 1);
    m_ready = 1'b1;
    drain();
    check("bp_outputs", out_total - o0, 2);

    // Timeout with a silent core, then a late core_ready during the guard cycle.
    core_delay = 0;
    o0 = out_total;
    push_word(32'h55);
    n = 0;
    while (!core_valid && n < 20) begin tick(); n++; end
    t0 = cyc;
    n = 0;
    while (!err_timeout && n < 60) begin tick(); n++; end
    check("tmo_latency", cyc - t0, TMO + 1);
    check("tmo_no_output", m_valid, 0);
    inj_req = 1'b1;
    tick();
    check("tmo_idle_after_hold", busy, 0);
    repeat (5) tick();
    check("tmo_late_ignored", out_total - o0, 0);
    check("tmo_sticky", err_timeout, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo_cleared", err_timeout, 0);

    // A timeout wins over a clear held in the same cycle.
    err_clr = 1'b1;
    push_word(32'h66);
    n = 0;
    while (!err_timeout && n < 60) begin tick(); n++; end
    check("tmo_set_wins", err_timeout, 1);
    tick();
    check("tmo_clear_after", err_timeout, 0);
    err_clr = 1'b0;
    repeat (2) tick();

    // Asynchronous reset while waiting on the core with three words queued.
    push_word(32'hC0);
    push_word(32'hC1);
    push_word(32'hC2);
    push_word(32'hC3);
    repeat (2) tick();
    check("mid_queued", fifo_count, 3);
    check("mid_busy", busy, 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_s_ready", s_ready, 1);
    check("arst_core_valid", core_valid, 0);
    check("arst_core_data", core_data, 0);
    check("arst_m_valid", m_valid, 0);
    check("arst_m_data", m_data, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err_timeout, 0);
    check("arst_count", fifo_count, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    core_delay = 2;
    p0 = pulses;
    repeat (10) tick();
    check("arst_no_stray_issue", pulses - p0, 0);
    check("arst_count_after", fifo_count, 0);

    // Held result released in the same cycle the next word issues.
    m_ready = 1'b0;
    o0 = out_total;
    push_word(32'hD0);
    push_word(32'hE0);
    n = 0;
    while (!m_valid && n < 50) begin tick(); n++; end
    check("sim_first", m_data, 32'hD1);
    m_ready = 1'b1;
    tick();
    check("sim_issue_on_release", {core_valid, core_data}, {1'b1, 32'hE0});
    check("sim_slot_cleared", m_valid, 0);
    drain();
    check("sim_outputs", out_total - o0, 2);

    // Randomized traffic, random core latency and random sink stalls.
    core_delay = 255;
    o0 = out_total;
    sent = 0;
    for (int c = 0; c < 800 && sent < 20; c++) begin
      if (!s_valid && $urandom_range(0, 2) != 0) begin
        s_valid = 1'b1;
        s_data  = $urandom;
      end
      m_ready = ($urandom_range(0, 3) != 0);
      go = s_valid && s_ready;
      tick();
      if (go) begin
        s_valid = 1'b0;
        sent++;
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    drain();
    check("rand_sent", sent, 20);
    check("rand_outputs", out_total - o0, 20);
    check("rand_err_clean", err_timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ai_core_driver.md
Name: ai_core_driver

Overview:
- Initiator side of the per-core compute handshake: buffers operand words from an upstream valid/ready stream and issues them one at a time to a compute core's data_in/input_valid port.
- Waits for the core's single-cycle ready pulse, captures the result, and presents it on a downstream valid/ready stream.
- Sits between the dispatch fabric and each compute core. Provides flow control, a response timeout and status for the controller.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits.
- FIFO_DEPTH, 4, input FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 15, maximum cycles spent in WAIT before the transaction is abandoned; ≥3.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_data  in  DATA_WIDTH  upstream operand.
- s_valid  in  1  upstream operand valid.
- s_ready  out  1  input FIFO not full.
- core_data  out  DATA_WIDTH  operand to core data_in.
- core_valid  out  1  one-cycle issue strobe to core input_valid.
- core_result  in  DATA_WIDTH  core data_out.
- core_ready  in  1  core result-valid pulse.
- m_data  out  DATA_WIDTH  result to downstream.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accept.
- busy  out  1  FSM not in IDLE or FIFO non-empty.
- err_timeout  out  1  sticky timeout flag.
- err_clr  in  1  clears err_timeout.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  input FIFO occupancy.

Behaviour:
- Reset (reset_n low, async): FIFO empty, s_ready=1, core_valid=0, core_data=0, m_valid=0, m_data=0, busy=0, err_timeout=0, fifo_count=0, FSM=IDLE, timeout counter=0.
- Input FIFO: push when s_valid&&s_ready. s_ready = (count<FIFO_DEPTH), registered from count, with no combinational path from m_ready. Simultaneous push and pop at full is not allowed, because s_ready=0. Simultaneous push and pop when non-full keeps count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE → ISSUE when the FIFO is non-empty and the output slot is free (m_valid=0, or m_valid&&m_ready this cycle). The FIFO pops and core_data loads the head word.
  - ISSUE: core_valid=1 for exactly this cycle; clear the timeout counter; go to WAIT. core_data holds its value until the next issue.
  - WAIT: core_ready=1 → m_data<=core_result, m_valid<=1, go to IDLE.
  - WAIT: otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, set err_timeout, drop the word (no m_valid), and go to HOLD.
  - HOLD: one cycle of guard so a late core_ready cannot alias onto the next issue; core_ready here is ignored; go to IDLE.
- Latency: with an idle core that responds 2 cycles after input_valid, s_valid accept → m_valid is 5 cycles (push, IDLE pop, ISSUE, core processing ×2 overlapping WAIT). The bench checks the exact cycle count.
- Only one transaction outstanding. core_ready outside WAIT is ignored.
- Output: m_valid holds, with m_data stable, until m_ready. It clears on m_valid&&m_ready unless a new result is captured in the same cycle, in which case m_valid stays 1 with new data.
- err_timeout is sticky. err_clr clears it. If a new timeout and err_clr occur in the same cycle, set wins.
- busy = (FSM≠IDLE) || (fifo_count≠0).
- Reset mid-transaction abandons all state. The core is reset by the same domain.
- No arithmetic on data. Widths pass through unchanged.

Decomposition:
- Shared package ai_accel_pkg holds the FSM state enum typedef drv_state_t and the localparam defaults for DATA_WIDTH and TIMEOUT_CYCLES.
- One sub-module is natural: sync_fifo (parameterised DATA_WIDTH/DEPTH, push/pop/full/empty/count). The driver FSM is top-level.

Test Plan:
- Single word: bench core model returns data+1 two cycles after core_valid. Push 0x0000_0010 → core_valid pulses once with core_data=0x10; m_valid with m_data=0x11 exactly 5 cycles after push; busy returns 0.
- Back-to-back: push 0x1,0x2,0x3,0x4,0x5 with m_ready=1. s_ready drops after 4 accepted while core is busy; outputs are 0x2..0x6 in order; exactly 5 core_valid pulses, never two within 3 cycles.
- Backpressure: m_ready=0 after the first result 0xA1. m_data stays 0xA1 and no second core_valid is issued until m_ready=1. The next result then follows with no loss.
- Timeout: core model never asserts core_ready. err_timeout rises TIMEOUT_CYCLES+1 cycles after core_valid; no m_valid; FSM reaches IDLE after HOLD. A late core_ready in HOLD produces no output. err_clr clears the flag.
- Reset mid-operation: deassert reset_n during WAIT with 3 words queued → all outputs at reset values immediately (async). After release, fifo_count=0 and no stray core_valid.
- Simultaneous release/capture: m_valid=1, m_ready=1 in the same cycle core_ready arrives → m_valid stays 1, m_data is the new result, previous result is counted once.
